// File: rtl/rcpu_mem_arbiter_if.sv
// Bundle of CPU, DMA and RAM signals around the shared program/data RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters' and RAM's view.
interface rcpu_mem_arbiter_if;
  logic        cpu_read_enable;
  logic        cpu_write_enable;
  logic [0:15] cpu_read_address;
  logic [0:15] cpu_write_address;
  logic [0:15] cpu_write_data;
  logic [0:15] cpu_read_data;
  logic        cpu_read_valid;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [0:15] dma_address;
  logic [0:15] dma_write_data;
  logic        dma_grant;
  logic [0:15] dma_read_data;
  logic        dma_read_valid;

  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [0:15] mem_read_address;
  logic [0:15] mem_write_address;
  logic [0:15] mem_write_data;
  logic [0:15] mem_read_data;

  modport slave (
    input  cpu_read_enable, cpu_write_enable, cpu_read_address, cpu_write_address,
           cpu_write_data, dma_req, dma_we, dma_address, dma_write_data, mem_read_data,
    output cpu_read_data, cpu_read_valid, cpu_stall, dma_grant, dma_read_data,
           dma_read_valid, mem_read_enable, mem_write_enable, mem_read_address,
           mem_write_address, mem_write_data
  );

  modport master (
    output cpu_read_enable, cpu_write_enable, cpu_read_address, cpu_write_address,
           cpu_write_data, dma_req, dma_we, dma_address, dma_write_data, mem_read_data,
    input  cpu_read_data, cpu_read_valid, cpu_stall, dma_grant, dma_read_data,
           dma_read_valid, mem_read_enable, mem_write_enable, mem_read_address,
           mem_write_address, mem_write_data
  );
endinterface

// File: rtl/rcpu_mem_arbiter.sv
// CPU-priority arbiter for the shared RAM with a DMA starvation counter and
// per-requester tagging of the one-cycle-latency read data.
module rcpu_mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  rcpu_mem_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic              cpu_active;
  logic              force_dma;
  logic              dma_grant;
  logic              cpu_stall;
  logic              mem_re;
  logic              mem_we;
  logic [0:15]       mem_raddr;
  logic [0:15]       mem_waddr;
  logic [0:15]       mem_wdata;

  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic              cpu_read_valid_d, cpu_read_valid_q;
  logic              dma_read_valid_d, dma_read_valid_q;

  always_comb begin
    cpu_active = bus.cpu_read_enable | bus.cpu_write_enable;
    force_dma  = (wait_cnt_q == MAX_CNT);
    dma_grant  = !reset & bus.dma_req & (!cpu_active | force_dma);
    cpu_stall  = !reset & cpu_active & dma_grant;

    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (dma_grant) begin
      mem_re    = !bus.dma_we;
      mem_we    = bus.dma_we;
      mem_raddr = bus.dma_address;
      mem_waddr = bus.dma_address;
      mem_wdata = bus.dma_write_data;
    end else if (!reset && cpu_active) begin
      // Read and write ports are independent, so a combined CPU access goes out whole.
      mem_re    = bus.cpu_read_enable;
      mem_we    = bus.cpu_write_enable;
      mem_raddr = bus.cpu_read_address;
      mem_waddr = bus.cpu_write_address;
      mem_wdata = bus.cpu_write_data;
    end

    if (dma_grant || !bus.dma_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == MAX_CNT) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    cpu_read_valid_d = bus.cpu_read_enable & !cpu_stall;
    dma_read_valid_d = dma_grant & !bus.dma_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q       <= '0;
      cpu_read_valid_q <= 1'b0;
      dma_read_valid_q <= 1'b0;
    end else begin
      wait_cnt_q       <= wait_cnt_d;
      cpu_read_valid_q <= cpu_read_valid_d;
      dma_read_valid_q <= dma_read_valid_d;
    end
  end

  assign bus.dma_grant         = dma_grant;
  assign bus.cpu_stall         = cpu_stall;
  assign bus.mem_read_enable   = mem_re;
  assign bus.mem_write_enable  = mem_we;
  assign bus.mem_read_address  = mem_raddr;
  assign bus.mem_write_address = mem_waddr;
  assign bus.mem_write_data    = mem_wdata;
  // Both requesters see the raw RAM output; the valids say whose result it is.
  assign bus.cpu_read_data     = bus.mem_read_data;
  assign bus.dma_read_data     = bus.mem_read_data;
  assign bus.cpu_read_valid    = cpu_read_valid_q;
  assign bus.dma_read_valid    = dma_read_valid_q;

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Directed bench for rcpu_mem_arbiter with a 4096x16 registered-read RAM model.
module tb_rcpu_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rcpu_mem_arbiter_if bus ();

  rcpu_mem_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [15:0] ram [0:4095];

  always @(posedge clk) begin
    if (bus.mem_write_enable) ram[bus.mem_write_address[4:15]] <= bus.mem_write_data;
    if (bus.mem_read_enable)  bus.mem_read_data <= ram[bus.mem_read_address[4:15]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_read_enable   = 1'b0;
    bus.cpu_write_enable  = 1'b0;
    bus.cpu_read_address  = 16'h0000;
    bus.cpu_write_address = 16'h0000;
    bus.cpu_write_data    = 16'h0000;
    bus.dma_req           = 1'b0;
    bus.dma_we            = 1'b0;
    bus.dma_address       = 16'h0000;
    bus.dma_write_data    = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.cpu_read_enable = 1'b1;
    bus.cpu_read_address = 16'h0007;
    bus.dma_req = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.dma_grant !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_grant_stall: got %b%b want 00", bus.dma_grant, bus.cpu_stall);
    end
    checks++;
    if (bus.mem_read_enable !== 1'b0 || bus.mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL reset_mem_en: got %b%b want 00", bus.mem_read_enable, bus.mem_write_enable);
    end
    checks++;
    if (bus.mem_read_address !== 16'h0000 || bus.mem_write_address !== 16'h0000 || bus.mem_write_data !== 16'h0000) begin
      errors++; $display("FAIL reset_mem_bus: got %h %h %h want 0", bus.mem_read_address, bus.mem_write_address, bus.mem_write_data);
    end
    checks++;
    if (bus.cpu_read_valid !== 1'b0 || bus.dma_read_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: got %b%b want 00", bus.cpu_read_valid, bus.dma_read_valid);
    end
    idle_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_dma_write_read();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1;
    bus.dma_address = 16'h0010; bus.dma_write_data = 16'h00A5;
    #1;
    checks++;
    if (bus.dma_grant !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL dma_wr_grant: got grant=%b stall=%b want 1 0", bus.dma_grant, bus.cpu_stall);
    end
    checks++;
    if (bus.mem_write_enable !== 1'b1 || bus.mem_read_enable !== 1'b0 ||
        bus.mem_write_address !== 16'h0010 || bus.mem_write_data !== 16'h00A5) begin
      errors++; $display("FAIL dma_wr_bus: got we=%b re=%b a=%h d=%h want 1 0 0010 00a5",
                         bus.mem_write_enable, bus.mem_read_enable, bus.mem_write_address, bus.mem_write_data);
    end
    tick();
    bus.dma_we = 1'b0;
    #1;
    checks++;
    if (bus.dma_grant !== 1'b1 || bus.mem_read_enable !== 1'b1 || bus.mem_read_address !== 16'h0010) begin
      errors++; $display("FAIL dma_rd_grant: got grant=%b re=%b a=%h want 1 1 0010",
                         bus.dma_grant, bus.mem_read_enable, bus.mem_read_address);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.dma_read_valid !== 1'b1 || bus.dma_read_data !== 16'h00A5 || bus.cpu_read_valid !== 1'b0) begin
      errors++; $display("FAIL dma_rd_data: got v=%b d=%h cv=%b want 1 00a5 0",
                         bus.dma_read_valid, bus.dma_read_data, bus.cpu_read_valid);
    end
    tick();
    checks++;
    if (bus.dma_read_valid !== 1'b0) begin
      errors++; $display("FAIL dma_rd_valid_drop: got %b want 0", bus.dma_read_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    logic [15:0] datas [3];
    addrs = '{16'h0020, 16'h0003, 16'h0004};
    datas = '{16'h5A5A, 16'h0333, 16'h0444};
    for (int i = 0; i < 3; i++) begin
      bus.dma_req = 1'b1; bus.dma_we = 1'b1;
      bus.dma_address = addrs[i]; bus.dma_write_data = datas[i];
      #1;
      checks++;
      if (bus.dma_grant !== 1'b1 || bus.mem_write_address !== addrs[i]) begin
        errors++; $display("FAIL b2b_wr%0d: got grant=%b a=%h want 1 %h", i, bus.dma_grant, bus.mem_write_address, addrs[i]);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      bus.dma_we = 1'b0; bus.dma_address = addrs[i];
      #1;
      if (i > 0) begin
        checks++;
        if (bus.dma_read_valid !== 1'b1 || bus.dma_read_data !== datas[i-1]) begin
          errors++; $display("FAIL b2b_rd%0d: got v=%b d=%h want 1 %h", i - 1, bus.dma_read_valid, bus.dma_read_data, datas[i-1]);
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.dma_read_valid !== 1'b1 || bus.dma_read_data !== 16'h0444) begin
      errors++; $display("FAIL b2b_rd2: got v=%b d=%h want 1 0444", bus.dma_read_valid, bus.dma_read_data);
    end
    tick();
  endtask

  task automatic test_starvation();
    bus.cpu_read_enable = 1'b1; bus.cpu_read_address = 16'h0010;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_address = 16'h0020;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.dma_grant !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_read_address !== 16'h0010) begin
        errors++; $display("FAIL starve_blocked_c%0d: got grant=%b stall=%b a=%h want 0 0 0010",
                           c, bus.dma_grant, bus.cpu_stall, bus.mem_read_address);
      end
      tick();
    end
    checks++;
    if (bus.dma_grant !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.mem_read_address !== 16'h0020) begin
      errors++; $display("FAIL starve_forced_c4: got grant=%b stall=%b a=%h want 1 1 0020",
                         bus.dma_grant, bus.cpu_stall, bus.mem_read_address);
    end
    tick();
    bus.dma_req = 1'b0;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.cpu_read_valid !== 1'b0 || bus.dma_read_valid !== 1'b1 ||
        bus.dma_read_data !== 16'h5A5A || bus.mem_read_address !== 16'h0010) begin
      errors++; $display("FAIL starve_c5: got stall=%b cv=%b dv=%b d=%h a=%h want 0 0 1 5a5a 0010",
                         bus.cpu_stall, bus.cpu_read_valid, bus.dma_read_valid, bus.dma_read_data, bus.mem_read_address);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.cpu_read_valid !== 1'b1 || bus.cpu_read_data !== 16'h00A5 || bus.dma_read_valid !== 1'b0) begin
      errors++; $display("FAIL starve_c6: got cv=%b d=%h dv=%b want 1 00a5 0",
                         bus.cpu_read_valid, bus.cpu_read_data, bus.dma_read_valid);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    bus.cpu_read_enable = 1'b1; bus.cpu_read_address = 16'h0003;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_address = 16'h0004;
    #1;
    checks++;
    if (bus.dma_grant !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_read_address !== 16'h0003) begin
      errors++; $display("FAIL simul_owner: got grant=%b stall=%b a=%h want 0 0 0003",
                         bus.dma_grant, bus.cpu_stall, bus.mem_read_address);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.cpu_read_valid !== 1'b1 || bus.cpu_read_data !== 16'h0333 || bus.dma_read_valid !== 1'b0) begin
      errors++; $display("FAIL simul_result: got cv=%b d=%h dv=%b want 1 0333 0",
                         bus.cpu_read_valid, bus.cpu_read_data, bus.dma_read_valid);
    end
    tick();
  endtask

  task automatic test_write_wrap();
    bus.cpu_write_enable = 1'b1; bus.cpu_write_address = 16'h1005; bus.cpu_write_data = 16'h1234;
    #1;
    checks++;
    if (bus.mem_write_enable !== 1'b1 || bus.mem_read_enable !== 1'b0 ||
        bus.mem_write_address !== 16'h1005 || bus.mem_write_data !== 16'h1234) begin
      errors++; $display("FAIL wrap_write: got we=%b re=%b a=%h d=%h want 1 0 1005 1234",
                         bus.mem_write_enable, bus.mem_read_enable, bus.mem_write_address, bus.mem_write_data);
    end
    tick();
    idle_inputs();
    bus.cpu_read_enable = 1'b1; bus.cpu_read_address = 16'h0005;
    #1;
    checks++;
    if (bus.mem_read_enable !== 1'b1 || bus.mem_read_address !== 16'h0005 || bus.mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL wrap_read_issue: got re=%b a=%h we=%b want 1 0005 0",
                         bus.mem_read_enable, bus.mem_read_address, bus.mem_write_enable);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.cpu_read_valid !== 1'b1 || bus.cpu_read_data !== 16'h1234) begin
      errors++; $display("FAIL wrap_read_data: got v=%b d=%h want 1 1234", bus.cpu_read_valid, bus.cpu_read_data);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    bus.cpu_read_enable = 1'b1; bus.cpu_read_address = 16'h0010;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_address = 16'h0020;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.dma_grant !== 1'b0) begin
        errors++; $display("FAIL rst_pre_c%0d: got grant=%b want 0", c, bus.dma_grant);
      end
      tick();
    end
    checks++;
    if (bus.cpu_read_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_valid: got %b want 1", bus.cpu_read_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cpu_read_valid !== 1'b0 || bus.mem_read_enable !== 1'b0 || bus.mem_write_enable !== 1'b0 ||
        bus.dma_grant !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rst_async: got cv=%b re=%b we=%b grant=%b stall=%b want 0 0 0 0 0",
                         bus.cpu_read_valid, bus.mem_read_enable, bus.mem_write_enable, bus.dma_grant, bus.cpu_stall);
    end
    tick();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.dma_grant !== 1'b0) begin
        errors++; $display("FAIL rst_post_c%0d: got grant=%b want 0", c, bus.dma_grant);
      end
      tick();
    end
    checks++;
    if (bus.dma_grant !== 1'b1 || bus.cpu_stall !== 1'b1) begin
      errors++; $display("FAIL rst_post_forced: got grant=%b stall=%b want 1 1", bus.dma_grant, bus.cpu_stall);
    end
    tick();
    idle_inputs();
    tick();
    // Reset asserted during a DMA read grant must suppress its result.
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_address = 16'h0020;
    #1;
    checks++;
    if (bus.dma_grant !== 1'b1) begin
      errors++; $display("FAIL rst_dma_pre: got grant=%b want 1", bus.dma_grant);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.dma_grant !== 1'b0 || bus.mem_read_enable !== 1'b0) begin
      errors++; $display("FAIL rst_dma_gate: got grant=%b re=%b want 0 0", bus.dma_grant, bus.mem_read_enable);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.dma_read_valid !== 1'b0) begin
      errors++; $display("FAIL rst_dma_novalid0: got %b want 0", bus.dma_read_valid);
    end
    tick();
    checks++;
    if (bus.dma_read_valid !== 1'b0) begin
      errors++; $display("FAIL rst_dma_novalid1: got %b want 0", bus.dma_read_valid);
    end
  endtask

  task automatic test_drop_rereq();
    bus.cpu_read_enable = 1'b1; bus.cpu_read_address = 16'h0010;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_address = 16'h0020;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (bus.dma_grant !== 1'b0) begin
        errors++; $display("FAIL drop_pre_c%0d: got grant=%b want 0", c, bus.dma_grant);
      end
      tick();
    end
    bus.dma_req = 1'b0;
    #1;
    checks++;
    if (bus.dma_grant !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL drop_gap: got grant=%b stall=%b want 0 0", bus.dma_grant, bus.cpu_stall);
    end
    tick();
    bus.dma_req = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.dma_grant !== 1'b0) begin
        errors++; $display("FAIL drop_re_c%0d: got grant=%b want 0", c, bus.dma_grant);
      end
      tick();
    end
    checks++;
    if (bus.dma_grant !== 1'b1 || bus.cpu_stall !== 1'b1) begin
      errors++; $display("FAIL drop_re_forced: got grant=%b stall=%b want 1 1", bus.dma_grant, bus.cpu_stall);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.mem_read_data = 16'h0000;
    test_reset();
    test_dma_write_read();
    test_back_to_back();
    test_starvation();
    test_simultaneous();
    test_write_wrap();
    test_reset_midflight();
    test_drop_rereq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
